nibble_feeder: RTL and testbench
================================

NIBBLE_FEEDER -- requirements
Module: nibble_feeder

Interface
REQ-001 Parameter BATCH, default 8, nibbles per accumulation batch, legal range 1..15.
REQ-002 Parameter DEPTH, default 4, input FIFO entries, power of two, at least 2.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port s_valid  input  1  upstream nibble offered.
REQ-006 Port s_data  input  4  upstream nibble, unsigned.
REQ-007 Port s_ready  output  1  feeder accepts a nibble this cycle.
REQ-008 Port flush  input  1  request early close of a non-empty batch.
REQ-009 Port acc_in  output  4  addend to downstream 5-bit accumulator.
REQ-010 Port acc_rst  output  1  synchronous clear to downstream accumulator.
REQ-011 Port batch_done  output  1  one-cycle pulse; batch_sum/batch_len valid.
REQ-012 Port batch_sum  output  5  completed batch total, equal to accumulator value this cycle.
REQ-013 Port batch_len  output  4  number of nibbles in completed batch.

Function
REQ-014 The block SHALL hold a DEPTH-entry FIFO; push when s_valid && s_ready; s_ready SHALL equal !full && !rst (no same-cycle pass-through when full).
REQ-015 A pushed nibble SHALL be visible at FIFO head no earlier than the next cycle (1-cycle latency from s_data to acc_in).
REQ-016 Internal state: 5-bit shadow sum and 4-bit count, both 0 after reset.
REQ-017 Each cycle, outside reset, exactly one action SHALL occur, in priority order: CLOSE, FEED, IDLE.
REQ-018 CLOSE SHALL occur when count==BATCH, or flush && count>0, or FIFO non-empty && shadow+head > 31 (6-bit compare).
REQ-019 On CLOSE: acc_rst=1, batch_done=1, batch_sum=shadow, batch_len=count, acc_in=0, no pop; shadow and count SHALL become 0 at the edge.
REQ-020 On FEED (FIFO non-empty, no CLOSE): acc_in=head, pop, shadow+=head, count+=1.
REQ-021 On IDLE (FIFO empty, no CLOSE): acc_in=0, acc_rst=0, batch_done=0; shadow and count unchanged.
REQ-022 A zero-valued nibble SHALL count toward batch_len like any other.
REQ-023 flush with count==0 SHALL be ignored; flush is level-sampled, no latching.
REQ-024 Pushes during a CLOSE cycle SHALL be accepted if not full.
REQ-025 acc_in, acc_rst, batch_done, batch_sum, batch_len SHALL be combinational from registered state and rst only (no s_* to output path).
REQ-026 batch_sum and batch_len SHALL be 0 when batch_done=0.
REQ-027 shadow SHALL never exceed 31, so the downstream accumulator never wraps.

Reset
REQ-028 While rst=1: acc_rst=1, acc_in=0, s_ready=0, batch_done=0; FIFO pointers, shadow, count cleared at the edge.
REQ-029 Reset mid-batch SHALL discard the partial batch and FIFO contents with no batch_done.

Structure
REQ-030 Shared package acc_pkg SHALL hold NIB_W=4, ACC_W=5, ACC_MAX=31.
REQ-031 FIFO SHALL be a sub-module nibble_fifo (params DEPTH, width NIB_W; ports push, pop, din, dout, full, empty).
REQ-032 Target size 120-400 RTL lines total.

Verification
REQ-033 rst high 2 cycles -> acc_rst=1, s_ready=0 throughout; cycle after release: s_ready=1, acc_rst=0, acc_in=0.
REQ-034 BATCH=3, push 3,5,7 on cycles 0,1,2 -> acc_in=3,5,7 on cycles 1,2,3; cycle 4: batch_done=1, sum=15, len=3, acc_rst=1.
REQ-035 BATCH=8, push 15,15,4 -> feed 15,15; next cycle CLOSE sum=30 len=2; following cycle acc_in=4.
REQ-036 BATCH=1, s_valid held high with 1,2,3,... -> s_ready drops once 4 entries held; every accepted nibble appears once, in order, each as its own batch (len=1).
REQ-037 flush with count=0 -> no batch_done; push 2,9 then flush with FIFO empty -> batch_done sum=11 len=2.
REQ-038 rst asserted after 2 of 8 nibbles fed -> no batch_done, FIFO empty, next batch starts with count 0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared widths and helpers for the nibble feeder and its downstream 5-bit accumulator.
// The per-cycle action is decoded once and then drives both the outputs and the state update.
package acc_pkg;

  localparam int NIB_W = 4;
  localparam int ACC_W = 5;
  localparam logic [ACC_W-1:0] ACC_MAX = 5'd31;

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_FEED  = 2'd1,
    ACT_CLOSE = 2'd2
  } action_e;

  // True when adding nib to shadow would exceed what the accumulator can hold.
  function automatic logic sum_overflows(input logic [ACC_W-1:0] shadow,
                                         input logic [NIB_W-1:0] nib);
    logic [ACC_W:0] total;
    total = {1'b0, shadow} + {{(ACC_W + 1 - NIB_W){1'b0}}, nib};
    return (total > {1'b0, ACC_MAX});
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Small synchronous FIFO for the incoming nibbles; no same-cycle pass-through.
// Pointers carry one extra wrap bit so full and empty are distinct.
module nibble_fifo
  import acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = NIB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/nibble_feeder.sv
// Feeds buffered nibbles into a downstream 5-bit accumulator, closing a batch on
// length, flush, or imminent overflow, and reporting each closed batch's total.
module nibble_feeder
  import acc_pkg::*;
#(
  parameter int BATCH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [NIB_W-1:0] s_data,
  output logic             s_ready,
  input  logic             flush,
  output logic [NIB_W-1:0] acc_in,
  output logic             acc_rst,
  output logic             batch_done,
  output logic [ACC_W-1:0] batch_sum,
  output logic [3:0]       batch_len
);

  localparam logic [3:0] BATCH_C = 4'(BATCH);

  logic [ACC_W-1:0] shadow_r;
  logic [3:0]       count_r;
  logic [NIB_W-1:0] head_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             close_s;
  action_e          action_s;

  assign s_ready = !full_s && !rst;
  assign push_s  = s_valid && s_ready;
  assign pop_s   = (action_s == ACT_FEED);

  nibble_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NIB_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (s_data),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Close conditions; a batch is never closed while empty since count is then 0.
  always_comb begin
    close_s = 1'b0;
    if (count_r == BATCH_C) begin
      close_s = 1'b1;
    end else if (flush && (count_r != 4'd0)) begin
      close_s = 1'b1;
    end else if (!empty_s && sum_overflows(shadow_r, head_s)) begin
      close_s = 1'b1;
    end else begin
      close_s = 1'b0;
    end
  end

  // Single action per cycle, CLOSE before FEED before IDLE.
  always_comb begin
    action_s = ACT_IDLE;
    if (rst) begin
      action_s = ACT_IDLE;
    end else if (close_s) begin
      action_s = ACT_CLOSE;
    end else if (!empty_s) begin
      action_s = ACT_FEED;
    end else begin
      action_s = ACT_IDLE;
    end
  end

  // Outputs depend only on registered state and rst, never on s_* inputs directly.
  always_comb begin
    acc_in     = {NIB_W{1'b0}};
    acc_rst    = 1'b0;
    batch_done = 1'b0;
    batch_sum  = {ACC_W{1'b0}};
    batch_len  = 4'd0;
    if (rst) begin
      acc_rst = 1'b1;
    end else begin
      case (action_s)
        ACT_CLOSE: begin
          acc_rst    = 1'b1;
          batch_done = 1'b1;
          batch_sum  = shadow_r;
          batch_len  = count_r;
        end
        ACT_FEED: begin
          acc_in = head_s;
        end
        default: begin
          acc_in = {NIB_W{1'b0}};
        end
      endcase
    end
  end

  // Shadow of the downstream accumulator plus the running batch length.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= {ACC_W{1'b0}};
      count_r  <= 4'd0;
    end else begin
      case (action_s)
        ACT_CLOSE: begin
          shadow_r <= {ACC_W{1'b0}};
          count_r  <= 4'd0;
        end
        ACT_FEED: begin
          shadow_r <= shadow_r + {{(ACC_W - NIB_W){1'b0}}, head_s};
          count_r  <= count_r + 4'd1;
        end
        default: begin
          shadow_r <= shadow_r;
          count_r  <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_feeder.sv
// Drives three feeders (BATCH 8, 3, 1) with shared stimulus and checks each one
// cycle by cycle against a queue-and-arithmetic model of the batching rules.
module tb_nibble_feeder;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [3:0] s_data;
  logic       flush;

  logic       rdy  [N];
  logic [3:0] ain  [N];
  logic       arst [N];
  logic       done [N];
  logic [4:0] bsum [N];
  logic [3:0] blen [N];

  int total;
  int bad;

  int m_batch [N];
  int m_q     [N][DEPTH];
  int m_n     [N];
  int m_sum   [N];
  int m_cnt   [N];

  nibble_feeder #(.BATCH(8), .DEPTH(DEPTH)) u_b8 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy[0]),
    .flush(flush), .acc_in(ain[0]), .acc_rst(arst[0]), .batch_done(done[0]),
    .batch_sum(bsum[0]), .batch_len(blen[0])
  );

  nibble_feeder #(.BATCH(3), .DEPTH(DEPTH)) u_b3 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy[1]),
    .flush(flush), .acc_in(ain[1]), .acc_rst(arst[1]), .batch_done(done[1]),
    .batch_sum(bsum[1]), .batch_len(blen[1])
  );

  nibble_feeder #(.BATCH(1), .DEPTH(DEPTH)) u_b1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy[2]),
    .flush(flush), .acc_in(ain[2]), .acc_rst(arst[2]), .batch_done(done[2]),
    .batch_sum(bsum[2]), .batch_len(blen[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Predicts this cycle's outputs for feeder k, compares, then advances the model.
  task automatic model_check(input int k, input logic r, input logic v,
                             input logic [3:0] d, input logic f);
    int    e_ready, e_arst, e_ain, e_done, e_sum, e_len, head;
    bit    close;
    string p;
    p = $sformatf("B%0d", m_batch[k]);
    e_ready = 0; e_arst = 1; e_ain = 0; e_done = 0; e_sum = 0; e_len = 0;
    if (r) begin
      m_n[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
    end else begin
      e_ready = (m_n[k] < DEPTH) ? 1 : 0;
      e_arst  = 0;
      head    = (m_n[k] > 0) ? m_q[k][0] : 0;
      close   = (m_cnt[k] == m_batch[k]) || (f && m_cnt[k] > 0) ||
                (m_n[k] > 0 && m_sum[k] + head > 31);
      if (close) begin
        e_arst = 1; e_done = 1; e_sum = m_sum[k]; e_len = m_cnt[k];
        m_sum[k] = 0; m_cnt[k] = 0;
      end else if (m_n[k] > 0) begin
        e_ain = head;
        for (int i = 0; i < DEPTH - 1; i++) m_q[k][i] = m_q[k][i+1];
        m_n[k]--;
        m_sum[k] += head;
        m_cnt[k]++;
      end
      if (v && e_ready == 1) begin
        m_q[k][m_n[k]] = int'(d);
        m_n[k]++;
      end
    end
    check({p, ".s_ready"},    int'(rdy[k]),  e_ready);
    check({p, ".acc_rst"},    int'(arst[k]), e_arst);
    check({p, ".acc_in"},     int'(ain[k]),  e_ain);
    check({p, ".batch_done"}, int'(done[k]), e_done);
    check({p, ".batch_sum"},  int'(bsum[k]), e_sum);
    check({p, ".batch_len"},  int'(blen[k]), e_len);
  endtask

  task automatic cycle(input logic r, input logic v, input logic [3:0] d, input logic f);
    rst = r; s_valid = v; s_data = d; flush = f;
    #1;
    for (int k = 0; k < N; k++) model_check(k, r, v, d, f);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    m_batch[0] = 8; m_batch[1] = 3; m_batch[2] = 1;
    for (int k = 0; k < N; k++) begin
      m_n[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
    end
    rst = 1'b1; s_valid = 1'b0; s_data = 4'd0; flush = 1'b0;

    // Reset held two cycles with traffic offered, then release.
    cycle(1'b1, 1'b1, 4'd9, 1'b0);
    cycle(1'b1, 1'b1, 4'd6, 1'b0);
    idle(1);

    // 3,5,7 back to back.
    cycle(1'b0, 1'b1, 4'd3, 1'b0);
    cycle(1'b0, 1'b1, 4'd5, 1'b0);
    cycle(1'b0, 1'b1, 4'd7, 1'b0);
    idle(4);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    idle(2);

    // Overflow close: 15,15,4.
    cycle(1'b0, 1'b1, 4'd15, 1'b0);
    cycle(1'b0, 1'b1, 4'd15, 1'b0);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    idle(5);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    idle(2);

    // Flush with nothing counted, then 2,9 and a flush on an empty FIFO.
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd2, 1'b0);
    cycle(1'b0, 1'b1, 4'd9, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    idle(2);

    // Valid held high with an incrementing stream to exercise back-pressure.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'(i + 1), 1'b0);
    idle(10);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    idle(2);

    // Reset in the middle of a batch with entries still queued.
    cycle(1'b0, 1'b1, 4'd1, 1'b0);
    cycle(1'b0, 1'b1, 4'd2, 1'b0);
    cycle(1'b0, 1'b1, 4'd3, 1'b0);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    cycle(1'b1, 1'b1, 4'd5, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 4'd6, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    idle(2);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
